// File: rtl/clkdiv_pkg.sv
// ============================================================================
// Module   : clkdiv_pkg
// Purpose  : Shared constants for the clock divider path.
// Revision : 1.0
// ============================================================================
`default_nettype none

package clkdiv_pkg;

  localparam int c_WIDTH   = 28;
  localparam int c_MIN_DIV = 2;

  localparam logic [1:0] c_IDLE  = 2'd0;
  localparam logic [1:0] c_RUN   = 2'd1;
  localparam logic [1:0] c_DRAIN = 2'd2;

endpackage

`default_nettype wire

// File: rtl/clkdiv_if.sv
// ============================================================================
// Module   : clkdiv_if
// Purpose  : Host-side run/stop and divisor handshake bundle.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface clkdiv_if
  import clkdiv_pkg::*;
#(
  parameter int WIDTH = c_WIDTH
);

  logic             start;
  logic             stop;
  logic [WIDTH-1:0] div_in;
  logic             div_load;
  logic             div_ready;
  logic             div_err;
  logic             running;
  logic [WIDTH-1:0] cur_div;

  modport master (
    output start, stop, div_in, div_load,
    input  div_ready, div_err, running, cur_div
  );

  modport slave (
    input  start, stop, div_in, div_load,
    output div_ready, div_err, running, cur_div
  );

endinterface

`default_nettype wire

// File: rtl/clkdiv_core.sv
// ============================================================================
// Module   : clkdiv_core
// Purpose  : Divisor counter with registered divided clock and period tick.
// Revision : 1.0
// ============================================================================
`default_nettype none

module clkdiv_core
  import clkdiv_pkg::*;
#(
  parameter int WIDTH = c_WIDTH
) (
  input  wire logic             clock_in,
  input  wire logic             reset_n,
  input  wire logic             enable,
  input  wire logic             clear,
  input  wire logic [WIDTH-1:0] active,
  output logic                  wrap,
  output logic                  clock_out,
  output logic                  tick
);

  logic [WIDTH-1:0] r_count;
  logic             r_clock_out;
  logic             r_tick;
  logic             w_last;

  assign w_last    = (r_count == active - WIDTH'(1));
  assign wrap      = enable && w_last;
  assign clock_out = r_clock_out;
  assign tick      = r_tick;

  // Outputs are derived from the pre-edge count, so they trail it by one cycle.
  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      r_count     <= '0;
      r_clock_out <= 1'b0;
      r_tick      <= 1'b0;
    end else begin
      if (clear || !enable || w_last) begin
        r_count <= '0;
      end else begin
        r_count <= r_count + WIDTH'(1);
      end
      r_clock_out <= enable && (r_count < (active >> 1));
      r_tick      <= wrap;
    end
  end

endmodule

`default_nettype wire

// File: rtl/clkdiv_ctrl.sv
// ============================================================================
// Module   : clkdiv_ctrl
// Purpose  : Run/stop FSM and divisor handshake around clkdiv_core.
// Revision : 1.0
// ============================================================================
`default_nettype none

module clkdiv_ctrl
  import clkdiv_pkg::*;
#(
  parameter int               WIDTH       = c_WIDTH,
  parameter logic [WIDTH-1:0] DEFAULT_DIV = WIDTH'(50_000_000),
  parameter int               MIN_DIV     = c_MIN_DIV
) (
  input  wire logic clock_in,
  input  wire logic reset_n,
  clkdiv_if.slave   bus,
  output logic      clock_out,
  output logic      tick
);

  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;
  logic [WIDTH-1:0] r_active;
  logic [WIDTH-1:0] r_pending;
  logic             r_pend_valid;
  logic             r_div_err;
  logic             w_run;
  logic             w_wrap;
  logic             w_accept;
  logic             w_bad;
  logic             w_go;

  assign w_run    = (r_state != c_IDLE);
  assign w_go     = bus.start && !bus.stop;
  assign w_accept = bus.div_load && !r_pend_valid;
  assign w_bad    = (bus.div_in < WIDTH'(MIN_DIV));

  assign bus.div_ready = !r_pend_valid;
  assign bus.div_err   = r_div_err;
  assign bus.running   = w_run;
  assign bus.cur_div   = r_active;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_IDLE:  if (w_go) w_state_nxt = c_RUN;
      c_RUN:   if (bus.stop) w_state_nxt = c_DRAIN;
      c_DRAIN: begin
        // A fresh start cancels the drain even on the boundary cycle.
        if (w_go)        w_state_nxt = c_RUN;
        else if (w_wrap) w_state_nxt = c_IDLE;
      end
      default: w_state_nxt = c_IDLE;
    endcase
  end

  // Accept only happens while nothing is pending, so store and apply never collide.
  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= c_IDLE;
      r_active     <= DEFAULT_DIV;
      r_pending    <= '0;
      r_pend_valid <= 1'b0;
      r_div_err    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_div_err <= w_accept && w_bad;
      if (w_accept && !w_bad) begin
        r_pending    <= bus.div_in;
        r_pend_valid <= 1'b1;
      end else if (r_pend_valid && (!w_run || w_wrap)) begin
        r_active     <= r_pending;
        r_pend_valid <= 1'b0;
      end
    end
  end

  clkdiv_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .clock_in  (clock_in),
    .reset_n   (reset_n),
    .enable    (w_run),
    .clear     (!w_run),
    .active    (r_active),
    .wrap      (w_wrap),
    .clock_out (clock_out),
    .tick      (tick)
  );

endmodule

`default_nettype wire

// File: tb/tb_clkdiv_ctrl.sv
// ============================================================================
// Module   : tb_clkdiv_ctrl
// Purpose  : Directed plus random stimulus against a period-level reference model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_clkdiv_ctrl;

  localparam int c_W       = 28;
  localparam int c_DEF_DIV = 50_000_000;

  logic clock_in = 1'b0;
  logic reset_n  = 1'b0;
  logic clock_out;
  logic tick;

  clkdiv_if #(.WIDTH(c_W)) bus ();

  clkdiv_ctrl u_dut (
    .clock_in  (clock_in),
    .reset_n   (reset_n),
    .bus       (bus),
    .clock_out (clock_out),
    .tick      (tick)
  );

  always #5 clock_in = ~clock_in;

  int n_pass  = 0;
  int n_total = 0;
  int n_fail  = 0;

  // Reference model: mode 0 idle / 1 run / 2 drain; pos is the position inside the period.
  int m_mode, m_div, m_pend, m_pos;
  bit e_clk, e_tick, e_err;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_div = c_DEF_DIV; m_pend = 0; m_pos = 0;
    e_clk = 0; e_tick = 0; e_err = 0;
  endtask

  task automatic model_edge();
    bit run, bnd, ready, go;
    run   = (m_mode != 0);
    bnd   = run && (m_pos == m_div - 1);
    ready = (m_pend == 0);
    go    = bus.start && !bus.stop;
    e_clk  = run && (m_pos < m_div / 2);
    e_tick = bnd;
    e_err  = bus.div_load && ready && (bus.div_in < 2);
    m_pos  = (!run || bnd) ? 0 : m_pos + 1;
    if (bus.div_load && ready && bus.div_in >= 2) m_pend = int'(bus.div_in);
    else if (m_pend != 0 && (!run || bnd)) begin
      m_div  = m_pend;
      m_pend = 0;
    end
    case (m_mode)
      0: if (go) m_mode = 1;
      1: if (bus.stop) m_mode = 2;
      default: if (go) m_mode = 1; else if (bnd) m_mode = 0;
    endcase
  endtask

  task automatic check_all();
    check("clock_out", 32'(clock_out), 32'(e_clk));
    check("tick", 32'(tick), 32'(e_tick));
    check("div_err", 32'(bus.div_err), 32'(e_err));
    check("running", 32'(bus.running), 32'(m_mode != 0));
    check("div_ready", 32'(bus.div_ready), 32'(m_pend == 0));
    check("cur_div", 32'(bus.cur_div), 32'(m_div));
  endtask

  task automatic cycle();
    @(posedge clock_in);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic idle_inputs();
    bus.start = 0; bus.stop = 0; bus.div_load = 0; bus.div_in = '0;
  endtask

  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic load(input int d);
    bus.div_in = c_W'(d); bus.div_load = 1;
    cycle();
    bus.div_load = 0;
  endtask

  task automatic pulse_start();
    bus.start = 1; cycle(); bus.start = 0;
  endtask

  task automatic pulse_stop();
    bus.stop = 1; cycle(); bus.stop = 0;
  endtask

  task automatic wait_pos(input int p);
    int k;
    k = 0;
    while (!(m_mode != 0 && m_pos == p) && k < 64) begin
      cycle();
      k++;
    end
    if (k >= 64) check("wait_pos_timeout", 32'(k), 32'(0));
  endtask

  task automatic wait_ready();
    int k;
    k = 0;
    while (m_pend != 0 && k < 64) begin
      cycle();
      k++;
    end
    if (k >= 64) check("wait_ready_timeout", 32'(k), 32'(0));
  endtask

  initial begin
    idle_inputs();
    model_reset();
    #12 reset_n = 1;
    #1 check_all();
    run_cycles(3);

    load(4);
    run_cycles(2);
    pulse_start();
    run_cycles(12);

    wait_pos(1);
    load(6);
    run_cycles(20);

    load(1);
    run_cycles(8);
    load(5);
    run_cycles(15);

    load(4);
    wait_ready();
    wait_pos(1);
    pulse_stop();
    run_cycles(8);

    pulse_start();
    wait_pos(1);
    pulse_stop();
    pulse_start();
    run_cycles(12);

    // Boundary stop with a pending divisor: both take effect together.
    wait_pos(2);
    load(3);
    pulse_stop();
    run_cycles(10);

    for (int i = 0; i < 400; i++) begin
      bus.start    = ($urandom_range(0, 9) == 0);
      bus.stop     = ($urandom_range(0, 14) == 0);
      bus.div_load = ($urandom_range(0, 7) == 0);
      bus.div_in   = c_W'($urandom_range(0, 9));
      cycle();
    end
    idle_inputs();

    if (m_mode == 0) pulse_start();
    run_cycles(2);
    wait_ready();
    load(7);
    run_cycles(1);
    #2 reset_n = 0;
    model_reset();
    #1 check_all();
    @(posedge clock_in);
    @(posedge clock_in);
    #3 reset_n = 1;
    #1 check_all();
    run_cycles(4);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
